// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-wide instruction prefetch queue fed by 16-bit bus fetches
module prefetch_queue #(
    parameter int QUEUE_BYTES = 6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [15:0]                        cs,
    input  logic [15:0]                        new_ip,
    input  logic                               load_new_ip,
    output logic [15:0]                        fetch_ip,
    output logic                               mem_access,
    input  logic                               mem_ack,
    output logic [18:0]                        mem_address,
    input  logic [15:0]                        mem_data,
    input  logic                               fifo_rd_en,
    output logic [7:0]                         fifo_rd_data,
    output logic                               fifo_empty,
    output logic [$clog2(QUEUE_BYTES+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(QUEUE_BYTES + 1);
    localparam int PW = $clog2(QUEUE_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSHING
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic          mem_access_q, mem_access_d;
    logic [18:0]   mem_address_q, mem_address_d;
    logic          odd_q, odd_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    queue_q [QUEUE_BYTES];

    logic [19:0]   phys_addr;
    logic          issue;
    logic          push;
    logic          pop;
    logic [1:0]    push_bytes;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_BYTES - 1)) ? '0 : p + PW'(1);
    endfunction

    assign phys_addr = {cs, 4'h0} + {4'h0, fetch_ip_q};

    always_comb begin
        state_d       = state_q;
        fetch_ip_d    = fetch_ip_q;
        mem_address_d = mem_address_q;
        odd_d         = odd_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        issue         = 1'b0;
        push          = 1'b0;
        push_bytes    = odd_q ? 2'd1 : 2'd2;
        pop           = fifo_rd_en && (count_q != '0) && !load_new_ip;

        // An odd address only needs one free slot because just the high byte is kept.
        case (state_q)
            S_IDLE: begin
                if (!load_new_ip &&
                    ((count_q <= CW'(QUEUE_BYTES - 2)) ||
                     (fetch_ip_q[0] && (count_q <= CW'(QUEUE_BYTES - 1))))) begin
                    issue   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                    push    = !load_new_ip;
                end else if (load_new_ip) begin
                    state_d = S_FLUSHING;
                end
            end
            S_FLUSHING: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_access_d = (state_d != S_IDLE);
        if (issue) begin
            mem_address_d = phys_addr[19:1];
            odd_d         = fetch_ip_q[0];
        end

        if (load_new_ip) begin
            fetch_ip_d = new_ip;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            count_d = count_q + CW'(push ? push_bytes : 2'd0) - CW'(pop);
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                fetch_ip_d = fetch_ip_q + {14'd0, push_bytes};
                wr_ptr_d   = odd_q ? ptr_inc(wr_ptr_q) : ptr_inc(ptr_inc(wr_ptr_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fetch_ip_q    <= '0;
            mem_access_q  <= 1'b0;
            mem_address_q <= '0;
            odd_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_ip_q    <= fetch_ip_d;
            mem_access_q  <= mem_access_d;
            mem_address_q <= mem_address_d;
            odd_q         <= odd_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Byte storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            if (odd_q) begin
                queue_q[wr_ptr_q] <= mem_data[15:8];
            end else begin
                queue_q[wr_ptr_q]          <= mem_data[7:0];
                queue_q[ptr_inc(wr_ptr_q)] <= mem_data[15:8];
            end
        end
    end

    assign fetch_ip     = fetch_ip_q;
    assign mem_access   = mem_access_q;
    assign mem_address  = mem_address_q;
    assign fifo_count   = count_q;
    assign fifo_empty   = (count_q == '0);
    assign fifo_rd_data = fifo_empty ? 8'h00 : queue_q[rd_ptr_q];

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue
module tb_prefetch_queue;
    logic        clk;
    logic        reset;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;
    logic [15:0] fetch_ip;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic [2:0]  fifo_count;

    prefetch_queue #(.QUEUE_BYTES(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .new_ip       (new_ip),
        .load_new_ip  (load_new_ip),
        .fetch_ip     (fetch_ip),
        .mem_access   (mem_access),
        .mem_ack      (mem_ack),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count)
    );

    typedef struct {
        logic [15:0] cs;
        logic [15:0] ip;
        logic [18:0] addr1;
        logic [18:0] addr2;
        logic [7:0]  first_byte;
        logic [2:0]  count1;
        logic [15:0] ip_after;
    } vec_t;

    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_lat  = 1;
    bit          rand_lat = 0;

    int          mcount;
    logic [15:0] mf, mh, mcs;
    bit          stale;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: byte at physical address a reads back as a[7:0].
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 1;
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset || !mem_access) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : ack_lat;
                if (cnt >= cur_lat) begin
                    mem_ack  = 1'b1;
                    mem_data = {mem_address[6:0], 1'b1, mem_address[6:0], 1'b0};
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
    end

    function automatic logic [19:0] phys(input logic [15:0] c, input logic [15:0] ip);
        return {c, 4'h0} + {4'h0, ip};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_access(input string name);
        for (int i = 0; i < 20; i++) begin
            if (mem_access) break;
            step();
        end
        chk(name, 32'(mem_access), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!mem_access) break;
            step();
        end
        chk("drain_idle", 32'(mem_access), 0);
    endtask

    task automatic restart(input logic [15:0] c, input logic [15:0] ip);
        cs = c;
        new_ip = ip;
        load_new_ip = 1'b1;
        step();
        load_new_ip = 1'b0;
    endtask

    initial begin
        int k;
        bit found;
        reset = 1'b1;
        cs = 16'h0000;
        new_ip = 16'h0000;
        load_new_ip = 1'b0;
        fifo_rd_en = 1'b0;

        vecs[0] = '{16'h0000, 16'h0100, 19'h00080, 19'h00081, 8'h00, 3'd2, 16'h0102};
        vecs[1] = '{16'h1000, 16'h0003, 19'h08001, 19'h08002, 8'h03, 3'd1, 16'h0004};
        vecs[2] = '{16'hF000, 16'hFFFE, 19'h7FFFF, 19'h78000, 8'hFE, 3'd2, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'h0010, 19'h00000, 19'h00001, 8'h00, 3'd2, 16'h0012};
        vecs[4] = '{16'h1234, 16'h5679, 19'h0BCDC, 19'h0BCDD, 8'hB9, 3'd1, 16'h567A};

        step();
        step();
        chk("rst_mem_access", 32'(mem_access), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_fetch_ip", 32'(fetch_ip), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_fifo_empty", 32'(fifo_empty), 1);
        chk("rst_fifo_rd_data", 32'(fifo_rd_data), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            restart(vecs[i].cs, vecs[i].ip);
            chk("vec_access_e0", 32'(mem_access), 0);
            chk("vec_empty_e0", 32'(fifo_empty), 1);
            chk("vec_fetch_ip_e0", 32'(fetch_ip), 32'(vecs[i].ip));
            step();
            chk("vec_access_e1", 32'(mem_access), 1);
            chk("vec_addr1", 32'(mem_address), 32'(vecs[i].addr1));
            step();
            chk("vec_access_e2", 32'(mem_access), 0);
            chk("vec_empty_e2", 32'(fifo_empty), 0);
            chk("vec_first_byte", 32'(fifo_rd_data), 32'(vecs[i].first_byte));
            chk("vec_count_e2", 32'(fifo_count), 32'(vecs[i].count1));
            chk("vec_fetch_ip_e2", 32'(fetch_ip), 32'(vecs[i].ip_after));
            step();
            chk("vec_access_e3", 32'(mem_access), 1);
            chk("vec_addr2", 32'(mem_address), 32'(vecs[i].addr2));
            step();
            chk("vec_access_e4", 32'(mem_access), 0);
        end

        // Continuous popping yields the byte stream in address order.
        fifo_rd_en = 1'b1;
        restart(16'h0000, 16'h0100);
        k = 0;
        for (int i = 0; i < 200 && k < 16; i++) begin
            if (!fifo_empty) begin
                chk("stream_byte", 32'(fifo_rd_data), 32'(k));
                k++;
            end
            step();
        end
        chk("stream_done", 32'(k), 16);
        fifo_rd_en = 1'b0;

        // Push and pop on the same edge at count 4.
        drain();
        restart(16'h0000, 16'h0000);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (fifo_count == 3'd4 && mem_ack) begin
                found = 1;
                break;
            end
            step();
        end
        chk("pushpop_found", 32'(found), 1);
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        chk("pushpop_count", 32'(fifo_count), 5);

        // Fill to capacity, then free space one byte at a time.
        drain();
        restart(16'h0000, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            if (fifo_count == 3'd6) break;
            step();
        end
        chk("full_count", 32'(fifo_count), 6);
        for (int i = 0; i < 5; i++) begin
            chk("full_no_req", 32'(mem_access), 0);
            step();
        end
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        chk("full_pop1_count", 32'(fifo_count), 5);
        for (int i = 0; i < 4; i++) begin
            chk("one_free_no_req", 32'(mem_access), 0);
            step();
        end
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        wait_access("refill_req");
        chk("refill_addr", 32'(mem_address), 32'h00003);

        // Flush while a slow transaction is in flight.
        drain();
        ack_lat = 3;
        restart(16'h0000, 16'h0000);
        wait_access("flush_req");
        chk("flush_first_addr", 32'(mem_address), 0);
        restart(16'h0000, 16'h0040);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            chk("flush_hold_access", 32'(mem_access), 1);
            chk("flush_hold_addr", 32'(mem_address), 0);
            chk("flush_empty", 32'(fifo_empty), 1);
            if (mem_ack) begin
                found = 1;
                break;
            end
            step();
        end
        chk("flush_acked", 32'(found), 1);
        step();
        chk("flush_discard_empty", 32'(fifo_empty), 1);
        chk("flush_access_drop", 32'(mem_access), 0);
        wait_access("flush_next_req");
        chk("flush_next_addr", 32'(mem_address), 32'h00020);
        for (int i = 0; i < 10; i++) begin
            if (!fifo_empty) break;
            step();
        end
        chk("flush_first_byte", 32'(fifo_rd_data), 32'h40);

        // Reset in the middle of a transaction.
        drain();
        restart(16'h0000, 16'h0200);
        for (int i = 0; i < 20; i++) begin
            if (!fifo_empty) break;
            step();
        end
        wait_access("midrst_req");
        reset = 1'b1;
        step();
        chk("midrst_access", 32'(mem_access), 0);
        chk("midrst_empty", 32'(fifo_empty), 1);
        chk("midrst_fetch_ip", 32'(fetch_ip), 0);
        chk("midrst_count", 32'(fifo_count), 0);
        reset = 1'b0;
        ack_lat = 1;

        // Randomised traffic against a byte-stream model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        rand_lat = 1;
        mcount = 0;
        mf = 16'h0000;
        mh = 16'h0000;
        mcs = cs;
        stale = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit lo, rd, acc, ack, popped;
            logic [15:0] nip, ncs;
            logic [19:0] hp;
            int n;
            hp = phys(mcs, mh);
            chk("rand_count", 32'(fifo_count), 32'(mcount));
            chk("rand_empty", 32'(fifo_empty), 32'(mcount == 0));
            chk("rand_rd_data", 32'(fifo_rd_data), (mcount == 0) ? 32'h0 : 32'(hp[7:0]));
            chk("rand_fetch_ip", 32'(fetch_ip), 32'(mf));
            chk("rand_no_overflow", 32'(mcount <= 6), 1);

            lo = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 99) < 55);
            nip = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
            ncs = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            load_new_ip = lo;
            fifo_rd_en = rd;
            if (lo) begin
                cs = ncs;
                new_ip = nip;
            end

            acc = mem_access;
            ack = mem_ack;
            popped = rd && !lo && (mcount != 0);
            n = 0;
            if (acc && ack && !stale && !lo) begin
                hp = phys(mcs, mf);
                chk("rand_mem_address", 32'(mem_address), 32'(hp[19:1]));
                n = mf[0] ? 1 : 2;
                mf = mf + 16'(n);
            end
            mcount = mcount + n - int'(popped);
            if (popped) mh = mh + 16'd1;
            if (lo) begin
                mcount = 0;
                mf = nip;
                mh = nip;
                mcs = ncs;
                stale = acc && !ack;
            end else if (acc && ack) begin
                stale = 0;
            end
            step();
        end
        load_new_ip = 1'b0;
        fifo_rd_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
